// File: rtl/rps_pkg.sv
// Shared types and helpers for the rock-paper-scissors match controller.
// Moves are one-hot; results and FSM states are shared by the judge and the top level.
package rps_pkg;

    localparam logic [2:0] ROCK     = 3'b001;
    localparam logic [2:0] PAPER    = 3'b010;
    localparam logic [2:0] SCISSORS = 3'b100;

    typedef enum logic [1:0] {
        NONE  = 2'b00,
        TIE   = 2'b01,
        A_WIN = 2'b10,
        B_WIN = 2'b11
    } result_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        JUDGE   = 3'd2,
        REPORT  = 3'd3,
        DONE    = 3'd4
    } state_t;

    function automatic logic is_onehot(input logic [2:0] m);
        return (m == ROCK) || (m == PAPER) || (m == SCISSORS);
    endfunction

endpackage

// File: rtl/rps_judge.sv
// Combinational round judge: two legal one-hot moves in, round result out.
// Identical moves tie; otherwise A wins on the three beating pairs, else B wins.
module rps_judge
    import rps_pkg::*;
(
    input  logic [2:0] move_a,
    input  logic [2:0] move_b,
    output result_t    res
);

    logic a_beats_b;

    always_comb begin
        a_beats_b = ((move_a == ROCK)     && (move_b == SCISSORS)) ||
                    ((move_a == SCISSORS) && (move_b == PAPER))    ||
                    ((move_a == PAPER)    && (move_b == ROCK));
        if (move_a == move_b)
            res = TIE;
        else if (a_beats_b)
            res = A_WIN;
        else
            res = B_WIN;
    end

endmodule

// File: rtl/rps_match_ctrl.sv
// Best-of-N rock-paper-scissors sequencer: collects both moves over valid/ready,
// judges each round, keeps scores and declares the match winner.
module rps_match_ctrl
    import rps_pkg::*;
#(
    parameter int WIN_TARGET  = 3,
    parameter int SCORE_W     = 3,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               a_valid,
    input  logic [2:0]         a_move,
    input  logic               b_valid,
    input  logic [2:0]         b_move,
    output logic               a_ready,
    output logic               b_ready,
    output logic               result_valid,
    output logic [1:0]         result,
    output logic [SCORE_W-1:0] score_a,
    output logic [SCORE_W-1:0] score_b,
    output logic               match_done,
    output logic               match_winner,
    output logic               busy,
    output logic               err_illegal
);

    localparam int                 TMR_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0]   TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [SCORE_W-1:0] SCORE_TGT = SCORE_W'(WIN_TARGET);

    state_t           state, state_nxt;
    logic             cap_a, cap_b;
    logic [2:0]       mv_a, mv_b;
    logic [TMR_W-1:0] tmr;
    logic             forfeit;
    result_t          result_q, judge_res, round_res;

    logic a_take, b_take, a_bad, b_bad;
    logic have_a, have_b, expire, target_hit;

    rps_judge u_judge (
        .move_a (mv_a),
        .move_b (mv_b),
        .res    (judge_res)
    );

    assign result = result_q;

    always_comb begin
        a_ready    = (state == COLLECT) && !cap_a;
        b_ready    = (state == COLLECT) && !cap_b;
        a_take     = a_valid && a_ready && is_onehot(a_move);
        b_take     = b_valid && b_ready && is_onehot(b_move);
        a_bad      = a_valid && a_ready && !is_onehot(a_move);
        b_bad      = b_valid && b_ready && !is_onehot(b_move);
        have_a     = cap_a || a_take;
        have_b     = cap_b || b_take;
        // A late capture landing on the expiry edge still counts as a normal move.
        expire     = (cap_a ^ cap_b) && !(a_take || b_take) && (tmr == TMR_LAST);
        target_hit = (score_a == SCORE_TGT) || (score_b == SCORE_TGT);
        round_res  = forfeit ? (cap_a ? A_WIN : B_WIN) : judge_res;

        state_nxt = state;
        unique case (state)
            IDLE, DONE: if (start) state_nxt = COLLECT;
            COLLECT:    if ((have_a && have_b) || expire) state_nxt = JUDGE;
            JUDGE:      state_nxt = REPORT;
            REPORT:     state_nxt = target_hit ? DONE : COLLECT;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_a        <= 1'b0;
            cap_b        <= 1'b0;
            mv_a         <= '0;
            mv_b         <= '0;
            tmr          <= '0;
            forfeit      <= 1'b0;
            result_q     <= NONE;
            result_valid <= 1'b0;
            score_a      <= '0;
            score_b      <= '0;
            match_done   <= 1'b0;
            match_winner <= 1'b0;
            busy         <= 1'b0;
            err_illegal  <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            err_illegal  <= 1'b0;
            busy         <= (state_nxt == COLLECT) || (state_nxt == JUDGE) ||
                            (state_nxt == REPORT);
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        cap_a        <= 1'b0;
                        cap_b        <= 1'b0;
                        mv_a         <= '0;
                        mv_b         <= '0;
                        tmr          <= '0;
                        forfeit      <= 1'b0;
                        result_q     <= NONE;
                        score_a      <= '0;
                        score_b      <= '0;
                        match_done   <= 1'b0;
                        match_winner <= 1'b0;
                    end
                end
                COLLECT: begin
                    err_illegal <= a_bad || b_bad;
                    if (a_take) begin
                        cap_a <= 1'b1;
                        mv_a  <= a_move;
                    end
                    if (b_take) begin
                        cap_b <= 1'b1;
                        mv_b  <= b_move;
                    end
                    if (expire)
                        forfeit <= 1'b1;
                    else if (cap_a ^ cap_b)
                        tmr <= tmr + 1'b1;
                end
                JUDGE: begin
                    result_q     <= round_res;
                    result_valid <= 1'b1;
                    if (round_res == A_WIN && score_a < SCORE_TGT)
                        score_a <= score_a + 1'b1;
                    if (round_res == B_WIN && score_b < SCORE_TGT)
                        score_b <= score_b + 1'b1;
                end
                REPORT: begin
                    if (target_hit) begin
                        match_done   <= 1'b1;
                        match_winner <= (score_b == SCORE_TGT);
                    end else begin
                        cap_a   <= 1'b0;
                        cap_b   <= 1'b0;
                        mv_a    <= '0;
                        mv_b    <= '0;
                        tmr     <= '0;
                        forfeit <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rps_match_ctrl.sv
// Directed bench for rps_match_ctrl with hand-computed expectations per scenario.
module tb_rps_match_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       a_valid = 1'b0, b_valid = 1'b0;
    logic [2:0] a_move = 3'b000, b_move = 3'b000;
    logic       a_ready, b_ready, result_valid, match_done, match_winner, busy, err_illegal;
    logic [1:0] result;
    logic [2:0] score_a, score_b;

    int n_checks = 0;
    int n_fail   = 0;

    rps_match_ctrl #(.WIN_TARGET(3), .SCORE_W(3), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_valid(a_valid), .a_move(a_move), .b_valid(b_valid), .b_move(b_move),
        .a_ready(a_ready), .b_ready(b_ready), .result_valid(result_valid), .result(result),
        .score_a(score_a), .score_b(score_b), .match_done(match_done),
        .match_winner(match_winner), .busy(busy), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fresh_match();
        a_valid = 0; b_valid = 0; start = 0;
        rst_n = 0; #3; rst_n = 1;
        step();
        start = 1; step(); start = 0;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if ({a_ready, b_ready, result_valid, match_done, match_winner, busy, err_illegal} !== 7'b0) begin n_fail++; $display("FAIL reset_flags got %b want 0000000", {a_ready, b_ready, result_valid, match_done, match_winner, busy, err_illegal}); end
        n_checks++; if ({result, score_a, score_b} !== 8'b0) begin n_fail++; $display("FAIL reset_result_scores got %b want 0", {result, score_a, score_b}); end
        rst_n = 1; step();
        start = 1; step(); start = 0;
        n_checks++; if ({busy, a_ready, b_ready} !== 3'b111) begin n_fail++; $display("FAIL start_collect got %b want 111", {busy, a_ready, b_ready}); end
        a_valid = 1; a_move = 3'b001; step(); a_valid = 0;
        n_checks++; if ({a_ready, b_ready} !== 2'b01) begin n_fail++; $display("FAIL a_captured got %b want 01", {a_ready, b_ready}); end
        rst_n = 0; #2;
        n_checks++; if ({a_ready, b_ready, busy, result_valid, err_illegal, match_done} !== 6'b0) begin n_fail++; $display("FAIL midround_reset got %b want 0", {a_ready, b_ready, busy, result_valid, err_illegal, match_done}); end
        rst_n = 1; step();
        start = 1; step(); start = 0;
        n_checks++; if ({busy, a_ready, b_ready} !== 3'b111) begin n_fail++; $display("FAIL after_reset_fresh got %b want 111", {busy, a_ready, b_ready}); end
    endtask

    task automatic test_same_cycle_win();
        fresh_match();
        a_valid = 1; a_move = 3'b001; b_valid = 1; b_move = 3'b100;
        step(); a_valid = 0; b_valid = 0;
        n_checks++; if ({result_valid, busy, a_ready, b_ready} !== 4'b0100) begin n_fail++; $display("FAIL judge_cycle got %b want 0100", {result_valid, busy, a_ready, b_ready}); end
        step();
        n_checks++; if ({result_valid, result} !== 3'b110) begin n_fail++; $display("FAIL awin_result got %b want 110", {result_valid, result}); end
        n_checks++; if ({score_a, score_b} !== {3'd1, 3'd0}) begin n_fail++; $display("FAIL awin_scores got %0d/%0d want 1/0", score_a, score_b); end
        step();
        n_checks++; if ({result_valid, a_ready, b_ready, result} !== 5'b01110) begin n_fail++; $display("FAIL next_round got %b want 01110", {result_valid, a_ready, b_ready, result}); end
    endtask

    task automatic test_tie();
        fresh_match();
        a_valid = 1; a_move = 3'b010; step(); a_valid = 0;
        for (int i = 0; i < 4; i++) step();
        n_checks++; if ({a_ready, b_ready, busy} !== 3'b011) begin n_fail++; $display("FAIL tie_waiting got %b want 011", {a_ready, b_ready, busy}); end
        b_valid = 1; b_move = 3'b010; step(); b_valid = 0;
        step();
        n_checks++; if ({result_valid, result} !== 3'b101) begin n_fail++; $display("FAIL tie_result got %b want 101", {result_valid, result}); end
        n_checks++; if ({score_a, score_b} !== 6'd0) begin n_fail++; $display("FAIL tie_scores got %0d/%0d want 0/0", score_a, score_b); end
    endtask

    task automatic test_illegal();
        fresh_match();
        a_valid = 1; a_move = 3'b011; step();
        n_checks++; if ({err_illegal, a_ready} !== 2'b11) begin n_fail++; $display("FAIL illegal_pulse got %b want 11", {err_illegal, a_ready}); end
        a_move = 3'b100; step(); a_valid = 0;
        n_checks++; if ({err_illegal, a_ready} !== 2'b00) begin n_fail++; $display("FAIL legal_capture got %b want 00", {err_illegal, a_ready}); end
        b_valid = 1; b_move = 3'b000; a_valid = 1; a_move = 3'b111; step(); a_valid = 0;
        n_checks++; if ({err_illegal, b_ready} !== 2'b11) begin n_fail++; $display("FAIL b_illegal got %b want 11", {err_illegal, b_ready}); end
        b_move = 3'b010; step(); b_valid = 0;
        step();
        n_checks++; if ({result_valid, result, err_illegal} !== 4'b1100) begin n_fail++; $display("FAIL scissors_paper got %b want 1100", {result_valid, result, err_illegal}); end
    endtask

    task automatic test_timeout();
        fresh_match();
        a_valid = 1; a_move = 3'b001; step(); a_valid = 0;
        for (int i = 0; i < 7; i++) step();
        n_checks++; if ({b_ready, busy} !== 2'b11) begin n_fail++; $display("FAIL before_expiry got %b want 11", {b_ready, busy}); end
        step();
        n_checks++; if ({b_ready, result_valid} !== 2'b00) begin n_fail++; $display("FAIL expiry_judge got %b want 00", {b_ready, result_valid}); end
        step();
        n_checks++; if ({result_valid, result, score_a, score_b} !== {1'b1, 2'b10, 3'd1, 3'd0}) begin n_fail++; $display("FAIL forfeit got %b want 1100010000", {result_valid, result, score_a, score_b}); end
        fresh_match();
        a_valid = 1; a_move = 3'b001; step(); a_valid = 0;
        for (int i = 0; i < 7; i++) step();
        b_valid = 1; b_move = 3'b010; step(); b_valid = 0;
        step();
        n_checks++; if ({result_valid, result, score_a, score_b} !== {1'b1, 2'b11, 3'd0, 3'd1}) begin n_fail++; $display("FAIL capture_at_expiry got %b want 1110000001", {result_valid, result, score_a, score_b}); end
    endtask

    task automatic play_round(input logic [2:0] am, input logic [2:0] bm);
        a_valid = 1; a_move = am; b_valid = 1; b_move = bm;
        step(); a_valid = 0; b_valid = 0;
        step();
    endtask

    task automatic test_match();
        fresh_match();
        play_round(3'b001, 3'b010); step();
        play_round(3'b100, 3'b100); step();
        play_round(3'b010, 3'b100);
        n_checks++; if ({score_a, score_b, result} !== {3'd0, 3'd2, 2'b11}) begin n_fail++; $display("FAIL mid_match got %b want 00001011", {score_a, score_b, result}); end
        step();
        play_round(3'b001, 3'b001); step();
        play_round(3'b100, 3'b001);
        n_checks++; if ({result_valid, result, score_b, match_done} !== {1'b1, 2'b11, 3'd3, 1'b0}) begin n_fail++; $display("FAIL final_report got %b want 1110110", {result_valid, result, score_b, match_done}); end
        step();
        n_checks++; if ({match_done, match_winner, busy, a_ready, b_ready} !== 5'b11000) begin n_fail++; $display("FAIL done_state got %b want 11000", {match_done, match_winner, busy, a_ready, b_ready}); end
        a_valid = 1; a_move = 3'b001; step(); step();
        n_checks++; if ({match_done, score_a, score_b, result_valid} !== {1'b1, 3'd0, 3'd3, 1'b0}) begin n_fail++; $display("FAIL done_ignores_moves got %b want 10000110", {match_done, score_a, score_b, result_valid}); end
        start = 1; step(); start = 0;
        n_checks++; if ({match_done, score_a, score_b, result, busy, a_ready, b_ready} !== {1'b0, 3'd0, 3'd0, 2'b00, 3'b111}) begin n_fail++; $display("FAIL restart got %b want 0 0 0 00 111", {match_done, score_a, score_b, result, busy, a_ready, b_ready}); end
        a_valid = 0;
    endtask

    task automatic test_ignored_start();
        fresh_match();
        a_valid = 1; a_move = 3'b010; step(); a_valid = 0;
        start = 1; step(); start = 0;
        n_checks++; if ({a_ready, b_ready} !== 2'b01) begin n_fail++; $display("FAIL start_in_collect got %b want 01", {a_ready, b_ready}); end
    endtask

    initial begin
        test_reset();
        test_same_cycle_win();
        test_tie();
        test_illegal();
        test_timeout();
        test_match();
        test_ignored_start();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rps_match_ctrl.md
# rps_match_ctrl

Sequencer for a best-of-N Rock-Paper-Scissors match. It collects one move per round from each player over valid/ready handshakes and rejects non-one-hot moves. It judges each round through a combinational judge sub-module, keeps both scores, and declares the match winner when a player reaches the target. It sits between the player input front-ends and the score/display logic.

## Interface
- WIN_TARGET, 3: round wins needed to take the match (1..7).
- SCORE_W, 3: score counter width; must hold WIN_TARGET.
- TIMEOUT_CYC, 255: cycles allowed for the second move after the first is captured (≥2).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin new match; honoured only in IDLE or DONE.
- a_valid / b_valid  in  1  player move offered.
- a_move / b_move  in  3  one-hot move: rock 001, paper 010, scissors 100.
- a_ready / b_ready  out  1  controller accepts that player's move.
- result_valid  out  1  one-cycle pulse; round result on `result`.
- result  out  2  NONE 00, TIE 01, A_WIN 10, B_WIN 11; held until next round.
- score_a / score_b  out  SCORE_W  rounds won.
- match_done  out  1  high in DONE.
- match_winner  out  1  0 = A, 1 = B; valid while match_done.
- busy  out  1  high in COLLECT, JUDGE, REPORT.
- err_illegal  out  1  one-cycle pulse when an offered move is not one-hot.

## Operation
- States: IDLE, COLLECT, JUDGE, REPORT, DONE.
- IDLE: on start, clear scores and result, then go to COLLECT.
- COLLECT:
  - a_ready stays high until A's move is captured; b_ready behaves the same for B.
  - Capture happens on valid & ready & one-hot.
  - A non-one-hot move (000, 011, 111, …) is not captured. err_illegal pulses and ready stays high.
  - If both players offer illegal moves in the same cycle, there is a single pulse.
  - Both moves captured, in the same cycle or different cycles: go to JUDGE.
- Timeout:
  - The timer starts on the first capture and counts cycles while the other move is missing.
  - At TIMEOUT_CYC the missing player forfeits. The result is a win for the present player and the FSM goes to JUDGE.
  - The timer does not run while neither move is captured.
  - A capture in the same cycle as expiry counts as a normal capture; the capture wins.
- JUDGE (1 cycle):
  - Rock beats scissors, scissors beats paper, paper beats rock. Identical moves give TIE.
  - The winner's score increments; a TIE leaves both scores unchanged.
- REPORT (1 cycle):
  - result_valid = 1.
  - If the updated score equals WIN_TARGET, go to DONE and set match_winner. Otherwise clear the captured moves and return to COLLECT.
- DONE: scores, result and match_winner are held. start clears everything and enters COLLECT; start also wins over a simultaneous move offer.
- start outside IDLE/DONE is ignored.
- Scores never exceed WIN_TARGET. No wrap is possible.
- Reset at any point, including mid-round: everything returns to reset values and captured moves are discarded.

## Timing
- Reset values: state IDLE, all ready 0, result_valid 0, result NONE, scores 0, match_done 0, match_winner 0, busy 0, err_illegal 0.
- start sampled at edge t: COLLECT from t+1; a_ready/b_ready are high in the cycle after t.
- Second capture at edge t: JUDGE during cycle t→t+1. Scores update at edge t+1. result_valid is high for cycle t+1→t+2.
- The next round's ready rises at edge t+2, so the minimum round period is 3 cycles.
- Forfeit: with the first capture at edge t, expiry occurs at edge t+TIMEOUT_CYC, then JUDGE.
- match_done rises at the edge after REPORT.
- err_illegal is registered: it pulses the cycle after the illegal offer.
- All outputs are registered except a_ready/b_ready, which are decoded from state and capture flags.

## Structure
- Package rps_pkg holds:
  - move constants ROCK/PAPER/SCISSORS;
  - result_t enum {NONE, TIE, A_WIN, B_WIN};
  - state_t enum;
  - function is_onehot().
- Sub-module rps_judge is purely combinational: two moves in, result_t out. Tie is asserted on a bitwise-equal compare.
- The top level holds the FSM, capture registers, timeout counter and score counters.

## Test plan
- Reset: assert rst_n=0 mid-COLLECT after A has been captured. All outputs return to reset values. After reset, start leads to a fresh COLLECT with nothing captured.
- A=001 and B=100 offered in the same cycle right after start: result_valid pulses 2 cycles later with result=A_WIN, score_a=1, score_b=0.
- A=010, then B=010 five cycles later: result=TIE and both scores remain 0.
- A offers 011: err_illegal pulses, a_ready stays 1 and nothing is captured. A then offers 100 and is captured.
- TIMEOUT_CYC=8, A=001 captured, B silent: after 8 cycles the result is A_WIN by forfeit and score_a=1. A second case has B's capture coincide with expiry, which must be judged normally.
- WIN_TARGET=3, B wins three rounds interleaved with ties: match_done=1, match_winner=1, score_b=3. Moves offered in DONE are not accepted. start then clears the scores to 0 and resumes COLLECT.
